// File: rtl/instr_fetch_pkg.sv
// Shared types and sizes for the byte-serial instruction fetch unit.
// Holds the default memory address width, instruction geometry and fetch FSM states.
// Imported by the fetch block; contains no logic.
package instr_fetch_pkg;

   // Default byte-address width of the instruction memory (64 bytes).
   localparam int ADDR_W          = 6;
   // Assembled instruction width and the number of byte reads needed to build it.
   localparam int INSTR_W         = 32;
   localparam int BYTES_PER_INSTR = 4;
   // Width of the byte-lane counter that walks 0..BYTES_PER_INSTR-1.
   localparam int BCNT_W          = 2;

   // FETCH: reading bytes from memory; VALID: holding a complete instruction for decode.
   typedef enum logic {
      FETCH = 1'b0,
      VALID = 1'b1
   } fetch_state_t;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads four bytes over an 8-bit port and hands a 32-bit word to decode.
// Latency: 4 cycles of byte reads then 1 VALID cycle; best case one instruction per 5 cycles.
// Backpressure: holds instr/instr_pc in VALID until instr_ready; halt freezes FETCH; redirect overrides all.
module instr_fetch #(
   parameter int ADDR_W   = instr_fetch_pkg::ADDR_W,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   // Instruction memory port (read-only use)
   output logic              mem_read_rq,
   output logic              mem_write_rq,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_write_data,
   input  logic [7:0]        mem_read_data,
   // Pipeline control
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   // Decode interface
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc
);

   import instr_fetch_pkg::*;

   // Reset fetch address, forced onto a word boundary.
   localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED =
      ADDR_W'(RESET_PC) & ~ADDR_W'(BYTES_PER_INSTR - 1);
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_INSTR - 1);

   fetch_state_t        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;

   // A byte is taken from memory only in an unhalted FETCH cycle that is not being redirected.
   logic                byte_take;
   logic                handshake;
   logic [ADDR_W-1:0]   redirect_aligned;

   // The low bits of a redirect target are dropped: fetch is always word aligned.
   logic                unused_redirect_lsbs;
   assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

   assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

   // Memory request generation; rst gating keeps the port idle while reset is held.
   always_comb begin
      byte_take   = rst && (state_q == FETCH) && !halt && !redirect_valid;
      mem_read_rq = byte_take;
   end

   assign mem_write_rq   = 1'b0;
   assign mem_write_data = 8'h00;
   // Address wraps naturally modulo 2^ADDR_W.
   assign mem_address    = pc_q + ADDR_W'(byte_cnt_q);

   assign instr_valid = (state_q == VALID);
   assign handshake   = instr_valid && instr_ready;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;

   // Next-state logic: redirect first, then byte assembly in FETCH or handshake in VALID.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      byte_cnt_d = byte_cnt_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;

      if (redirect_valid) begin
         // A coincident handshake is simply consumed; the redirect target wins either way.
         state_d    = FETCH;
         pc_d       = redirect_aligned;
         byte_cnt_d = '0;
         instr_d    = '0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (byte_take) begin
                  // Inline byte-lane assembler: little-endian, lane selected by byte_cnt.
                  for (int b = 0; b < BYTES_PER_INSTR; b++) begin
                     if (byte_cnt_q == BCNT_W'(b)) begin
                        instr_d[8*b +: 8] = mem_read_data;
                     end
                  end
                  if (byte_cnt_q == LAST_BYTE) begin
                     state_d    = VALID;
                     instr_pc_d = pc_q;
                     pc_d       = pc_q + ADDR_W'(BYTES_PER_INSTR);
                     byte_cnt_d = '0;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end
            VALID: begin
               // halt is deliberately ignored here so a finished word can still drain.
               if (handshake) begin
                  state_d = FETCH;
               end
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC_ALIGNED;
         byte_cnt_q <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         byte_cnt_q <= byte_cnt_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

endmodule : instr_fetch
